mem_copy_initiator: RTL and testbench

- Word-copy DMA initiator that drives the data-memory request/valid protocol from the requester side, the role the core normally plays.
- Reads a word from src, writes it to dst, and repeats for len words.
- Sits beside the core on the datamem_top port. An external arbiter mux, outside this block, selects which requester owns the port.
- Used for memory init/clear-copy without software loops.

---
 rtl/mem_copy_initiator.sv | 156 +++++++++++++++
 tb/tb_mem_copy_initiator.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_initiator.sv
// mem_copy_initiator: word-copy DMA requester for the data-memory port.
// Reads one word from the source pointer, writes it to the destination
// pointer, and repeats for len words. Pointers are word addresses and wrap.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RD   | read request to source pointer held until mem_valid
// S_WR   | write request to destination pointer held until mem_valid
// S_FIN  | one-cycle done pulse, then back to idle
module mem_copy_initiator #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned ADDR_W  = 12
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [31:0]       src_addr_i,
   input  logic [31:0]       dst_addr_i,
   input  logic [ADDR_W-1:0] len_words_i,
   input  logic              abort_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic [ADDR_W-1:0] words_done_o,
   output logic              mem_request_o,
   output logic              mem_we_re_o,
   output logic [ADDR_W-1:0] mem_address_o,
   output logic [31:0]       mem_data_out_o,
   output logic [3:0]        mem_mask_o,
   output logic              mem_load_o,
   input  logic              mem_valid_i,
   input  logic [31:0]       mem_rdata_i
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   localparam logic [7:0]        TMO   = 8'(TIMEOUT);
   localparam logic [ADDR_W-1:0] ONE_W = ADDR_W'(1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] words_q, words_d;
   logic [31:0]       data_q, data_d;
   logic [7:0]        wait_q, wait_d;
   logic              error_q, error_d;

   logic misaligned;
   logic unused_addr;

   assign misaligned  = (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00);
   // Only the word-address slice of the byte addresses is used.
   assign unused_addr = ^{src_addr_i[31:ADDR_W+2], dst_addr_i[31:ADDR_W+2]};

   // Next-state logic: mem_valid beats abort, abort beats timeout.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      words_d = words_q;
      data_d  = data_q;
      wait_d  = wait_q;
      error_d = error_q;
      case (state_q)
         S_IDLE: begin
            wait_d = '0;
            if (start_i) begin
               words_d = '0;
               error_d = 1'b0;
               if (misaligned) begin
                  error_d = 1'b1;
                  state_d = S_FIN;
               end else if (len_words_i == '0) begin
                  state_d = S_FIN;
               end else begin
                  src_d   = src_addr_i[ADDR_W+1:2];
                  dst_d   = dst_addr_i[ADDR_W+1:2];
                  len_d   = len_words_i;
                  state_d = S_RD;
               end
            end
         end
         S_RD, S_WR: begin
            if (mem_valid_i) begin
               wait_d = '0;
               if (state_q == S_RD) begin
                  data_d  = mem_rdata_i;
                  state_d = abort_i ? S_FIN : S_WR;
               end else begin
                  words_d = words_q + ONE_W;
                  src_d   = src_q + ONE_W;
                  dst_d   = dst_q + ONE_W;
                  state_d = (abort_i || ((words_q + ONE_W) == len_q)) ? S_FIN : S_RD;
               end
            end else if (abort_i) begin
               state_d = S_FIN;
            end else if ((wait_q + 8'd1) == TMO) begin
               // Access is dropped; the responder never completed it.
               error_d = 1'b1;
               state_d = S_FIN;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         default: begin
            wait_d  = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         words_q <= '0;
         data_q  <= '0;
         wait_q  <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         words_q <= words_d;
         data_q  <= data_d;
         wait_q  <= wait_d;
         error_q <= error_d;
      end
   end

   // Memory-port outputs decode straight from state so reset drops them at once.
   always_comb begin
      busy_o         = (state_q != S_IDLE);
      done_o         = (state_q == S_FIN);
      error_o        = error_q;
      words_done_o   = words_q;
      mem_request_o  = (state_q == S_RD) || (state_q == S_WR);
      mem_we_re_o    = (state_q == S_WR);
      mem_load_o     = (state_q == S_RD);
      mem_mask_o     = mem_request_o ? 4'b1111 : 4'b0000;
      mem_data_out_o = data_q;
      mem_address_o  = '0;
      if (state_q == S_RD) mem_address_o = src_q;
      if (state_q == S_WR) mem_address_o = dst_q;
   end

endmodule

// File: tb/tb_mem_copy_initiator.sv
module tb_mem_copy_initiator;
   localparam int AW  = 12;
   localparam int TMO = 255;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [31:0]   src, dst;
   logic [AW-1:0] len;
   logic          abort;
   logic          busy, done, error;
   logic [AW-1:0] words_done;
   logic          req, we;
   logic [AW-1:0] addr;
   logic [31:0]   wdata;
   logic [3:0]    mask;
   logic          load;
   logic          valid = 1'b0;
   logic [31:0]   rdata = 32'h0;

   always #5 clk = ~clk;

   mem_copy_initiator #(.TIMEOUT(TMO), .ADDR_W(AW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .src_addr_i(src),
      .dst_addr_i(dst), .len_words_i(len), .abort_i(abort), .busy_o(busy),
      .done_o(done), .error_o(error), .words_done_o(words_done),
      .mem_request_o(req), .mem_we_re_o(we), .mem_address_o(addr),
      .mem_data_out_o(wdata), .mem_mask_o(mask), .mem_load_o(load),
      .mem_valid_i(valid), .mem_rdata_i(rdata)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Responder memory and reference image of what memory must hold.
   logic [31:0] mem     [0:4095];
   logic [31:0] ref_mem [0:4095];
   int rsp_delay  = 1;
   bit rsp_never  = 0;
   bit rsp_toggle = 0;
   int rsp_cnt    = 0;

   // Responder: valid after rsp_delay extra cycles of a held request, one cycle wide.
   always @(negedge clk) begin
      if (rsp_toggle) begin
         valid = ~valid;
      end else begin
         if (valid) begin
            valid   = 1'b0;
            rsp_cnt = 0;
         end
         if (req && !rsp_never) begin
            if (rsp_cnt >= rsp_delay) begin
               valid = 1'b1;
               if (we) mem[addr] = wdata;
               else    rdata = mem[addr];
            end else begin
               rsp_cnt++;
            end
         end else begin
            rsp_cnt = 0;
         end
      end
   end

   typedef struct {bit w; logic [AW-1:0] a; logic [31:0] d;} acc_t;
   acc_t          exp_q[$];
   acc_t          e;
   logic [AW-1:0] rd_log[$];
   int            req_cycles = 0;
   int            acc_done   = 0;
   bit            cmp_en     = 0;
   logic          prev_req = 1'b0, prev_valid = 1'b0, prev_we = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [31:0]   prev_wdata = '0;

   // Per-cycle comparison of the memory port against the expected access list.
   always @(negedge clk) begin
      #2;
      if (cmp_en) begin
         if (req) begin
            req_cycles++;
            chk("mask", {28'b0, mask}, 32'hF);
            chk("load", {31'b0, load}, {31'b0, !we});
            chk("busy_req", {31'b0, busy}, 32'd1);
            if (prev_req && !prev_valid) begin
               chk("hold_we", {31'b0, we}, {31'b0, prev_we});
               chk("hold_addr", {20'b0, addr}, {20'b0, prev_addr});
               if (we) chk("hold_wdata", wdata, prev_wdata);
            end
            if (valid) begin
               chk("access_expected", {31'b0, exp_q.size() != 0}, 32'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("acc_we", {31'b0, we}, {31'b0, e.w});
                  chk("acc_addr", {20'b0, addr}, {20'b0, e.a});
                  if (e.w) chk("acc_wdata", wdata, e.d);
                  acc_done++;
                  if (!we) rd_log.push_back(addr);
               end
            end
         end
         prev_req   = req;
         prev_valid = valid;
         prev_we    = we;
         prev_addr  = addr;
         prev_wdata = wdata;
      end
   end

   task automatic run(input logic [31:0] s, input logic [31:0] d, input int ln,
                      input int dly, input bit never, input int abort_w,
                      input bit exp_err, input int exp_words, input int exp_lat,
                      input int exp_reqs, input bit full);
      int            c0;
      bit            seen;
      logic [AW-1:0] ra, wa;
      logic [31:0]   dv;
      seen = 0;
      exp_q.delete();
      rd_log.delete();
      if (s[1:0] == 2'b00 && d[1:0] == 2'b00) begin
         for (int i = 0; i < ln; i++) begin
            ra = AW'((s >> 2) + 32'(i));
            wa = AW'((d >> 2) + 32'(i));
            dv = ref_mem[ra];
            exp_q.push_back('{1'b0, ra, 32'h0});
            exp_q.push_back('{1'b1, wa, dv});
            ref_mem[wa] = dv;
         end
      end
      req_cycles = 0;
      acc_done   = 0;
      rsp_delay  = dly;
      rsp_never  = never;
      @(negedge clk);
      src = s; dst = d; len = AW'(ln); start = 1'b1;
      c0 = cyc;
      @(negedge clk);
      start = 1'b0;
      #3;
      for (int i = 0; i < 2000; i++) begin
         if (done) begin
            seen = 1;
            break;
         end
         if (abort_w >= 0 && req && we && words_done == AW'(abort_w)) abort = 1'b1;
         @(negedge clk);
         #3;
      end
      chk("done_seen", {31'b0, seen}, 32'd1);
      chk("error", {31'b0, error}, {31'b0, exp_err});
      chk("busy_at_done", {31'b0, busy}, 32'd1);
      if (exp_words >= 0) chk("words_done", {20'b0, words_done}, 32'(exp_words));
      if (exp_lat >= 0)   chk("latency", 32'(cyc - c0 + 1), 32'(exp_lat));
      if (exp_reqs >= 0)  chk("req_cycles", 32'(req_cycles), 32'(exp_reqs));
      if (full) begin
         chk("queue_left", 32'(exp_q.size()), 32'd0);
         chk("accesses", 32'(acc_done), 32'(2 * ln));
      end
      @(negedge clk);
      abort = 1'b0;
      #3;
      chk("busy_after", {31'b0, busy}, 32'd0);
      chk("done_after", {31'b0, done}, 32'd0);
      exp_q.delete();
      rsp_never = 0;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem[i]     = 32'h5A000000 ^ (32'(i) * 32'h00010101);
         ref_mem[i] = 32'h5A000000 ^ (32'(i) * 32'h00010101);
      end
      mem[16] = 32'hAAAA0001; ref_mem[16] = 32'hAAAA0001;
      mem[17] = 32'hBBBB0002; ref_mem[17] = 32'hBBBB0002;
      mem[18] = 32'hCCCC0003; ref_mem[18] = 32'hCCCC0003;

      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      src = '0; dst = '0; len = '0;
      rsp_toggle = 1;
      repeat (4) @(negedge clk);
      #3;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_error", {31'b0, error}, 32'd0);
      chk("rst_words", {20'b0, words_done}, 32'd0);
      chk("rst_req", {31'b0, req}, 32'd0);
      chk("rst_we", {31'b0, we}, 32'd0);
      chk("rst_addr", {20'b0, addr}, 32'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_mask", {28'b0, mask}, 32'd0);
      chk("rst_load", {31'b0, load}, 32'd0);
      rsp_toggle = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #3;
         chk("idle_no_req", {31'b0, req}, 32'd0);
      end
      cmp_en = 1;

      // Basic copy: 3 words, next-cycle responder, 4*len+2 cycles.
      run(32'h40, 32'h100, 3, 1, 0, -1, 0, 3, 14, 12, 1);
      chk("basic_rd0", {20'b0, rd_log[0]}, 32'h010);
      chk("basic_rd2", {20'b0, rd_log[2]}, 32'h012);
      chk("basic_mem40", mem[12'h040], 32'hAAAA0001);
      chk("basic_mem41", mem[12'h041], 32'hBBBB0002);
      chk("basic_mem42", mem[12'h042], 32'hCCCC0003);

      // Wait states: 3 extra cycles per access.
      run(32'h200, 32'h300, 2, 3, 0, -1, 0, 2, 18, 16, 1);
      chk("wait_mem", mem[12'h0C1], ref_mem[12'h0C1]);

      // Misaligned source, then zero length clearing the sticky error.
      run(32'h42, 32'h100, 3, 1, 0, -1, 1, -1, 2, 0, 0);
      run(32'h40, 32'h100, 0, 1, 0, -1, 0, -1, 2, 0, 0);

      // Pointer wrap from the top word back to zero.
      run(32'h3FFC, 32'h2000, 2, 1, 0, -1, 0, 2, 10, 8, 1);
      chk("wrap_rd0", {20'b0, rd_log[0]}, 32'hFFF);
      chk("wrap_rd1", {20'b0, rd_log[1]}, 32'h000);

      // Timeout: no responder, access dropped after TMO waiting cycles.
      run(32'h40, 32'h500, 1, 1, 1, -1, 1, 0, TMO + 2, TMO, 0);

      // Abort during the write of word 2.
      run(32'h600, 32'h700, 4, 1, 0, 1, 0, 1, 9, 7, 0);
      chk("abort_accesses", 32'(acc_done), 32'd3);

      // Reset in the middle of a copy drops the request immediately.
      cmp_en = 0;
      @(negedge clk);
      src = 32'h40; dst = 32'h800; len = 12'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #3;
      chk("pre_reset_req", {31'b0, req}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_req", {31'b0, req}, 32'd0);
      chk("mid_reset_busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
